// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AddRoundKey round controller.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES   = 16;
    localparam int unsigned AES_NPASS_DEFAULT = 11;
    localparam int unsigned AES_ST_W          = 3;

    // Controller states, kept as plain constants for legacy tool flows
    typedef logic [AES_ST_W-1:0] aes_state_t;

    localparam aes_state_t ST_IDLE    = 3'd0;
    localparam aes_state_t ST_LOAD    = 3'd1;
    localparam aes_state_t ST_FEED    = 3'd2;
    localparam aes_state_t ST_CAPTURE = 3'd3;
    localparam aes_state_t ST_GAP     = 3'd4;
    localparam aes_state_t ST_OUT     = 3'd5;

    // Round-key byte address: pass*16 + byte index
    function automatic logic [15:0] aes_key_addr(input logic [3:0] pass_i,
                                                 input logic [3:0] idx_i);
        return {8'h00, pass_i, idx_i};
    endfunction

endpackage

// File: rtl/aes_state_buf.sv
// 16x8 state buffer: one synchronous write port, one asynchronous read port.
module aes_state_buf
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [AES_BLOCK_BYTES];

    // Contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer: load a 16-byte block, run NPASS key-add passes, stream result out.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NPASS = AES_NPASS_DEFAULT,
    parameter int unsigned RK_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [RK_AW-1:0] rk_addr,
    input  logic [7:0]       rk_rdata,
    output logic [7:0]       dp_col_din,
    output logic [7:0]       dp_key_din,
    output logic             dp_en_col,
    output logic             dp_en_key,
    input  logic [7:0]       dp_dout,
    input  logic             dp_enable_out,
    output logic             busy,
    output logic [3:0]       pass_idx
);

    localparam int unsigned CNT_W     = 5;
    localparam logic [3:0]  LAST_PASS = 4'(NPASS - 1);

    aes_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        pass_q, pass_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic              dp_en_q, dp_en_d;
    logic [7:0]        dp_col_q, dp_col_d;
    logic [RK_AW-1:0]  rk_addr_q, rk_addr_d;
    logic              busy_q, busy_d;
    logic [3:0]        pass_idx_q, pass_idx_d;

    logic              in_hs, out_hs;
    logic              buf_we;
    logic [3:0]        buf_waddr, buf_raddr;
    logic [7:0]        buf_wdata, buf_rdata;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    aes_state_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // Next state, counters and buffer write port
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        buf_we    = 1'b0;
        buf_waddr = cnt_q[3:0];
        buf_wdata = in_byte;
        case (state_q)
            ST_IDLE: begin
                buf_waddr = 4'd0;
                if (in_hs) begin
                    buf_we  = 1'b1;
                    cnt_d   = 5'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    buf_we = 1'b1;
                    if (cnt_q == 5'd15) begin
                        cnt_d   = '0;
                        pass_d  = '0;
                        state_d = ST_FEED;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_FEED: begin
                if (cnt_q == 5'd16) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_CAPTURE: begin
                buf_wdata = dp_dout;
                if (dp_enable_out) begin
                    buf_we = 1'b1;
                    if (cnt_q == 5'd15) begin
                        // The datapath repeats byte 15 next cycle; GAP ignores it
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_GAP: begin
                if (!dp_enable_out) begin
                    if (pass_q == LAST_PASS) begin
                        pass_d  = '0;
                        state_d = ST_OUT;
                    end else begin
                        pass_d  = pass_q + 4'd1;
                        state_d = ST_FEED;
                    end
                end
            end
            ST_OUT: begin
                if (out_hs) begin
                    if (cnt_q == 5'd15) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pass_d  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from next state/counters
    always_comb begin
        buf_raddr = cnt_d[3:0];
        if (state_d == ST_FEED) begin
            buf_raddr = 4'(cnt_d - 5'd1);
        end
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_OUT);
        out_byte_d  = out_valid_d ? buf_rdata : 8'h00;
        dp_en_d     = (state_d == ST_FEED) && (cnt_d != 5'd0);
        dp_col_d    = dp_en_d ? buf_rdata : 8'h00;
        rk_addr_d   = '0;
        if ((state_d == ST_FEED) && (cnt_d < 5'd16)) begin
            rk_addr_d = RK_AW'(aes_key_addr(pass_d, cnt_d[3:0]));
        end
        busy_d     = (state_d != ST_IDLE);
        pass_idx_d = ((state_d == ST_FEED) || (state_d == ST_CAPTURE) ||
                      (state_d == ST_GAP)) ? pass_d : 4'd0;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pass_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            dp_en_q     <= 1'b0;
            dp_col_q    <= '0;
            rk_addr_q   <= '0;
            busy_q      <= 1'b0;
            pass_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            dp_en_q     <= dp_en_d;
            dp_col_q    <= dp_col_d;
            rk_addr_q   <= rk_addr_d;
            busy_q      <= busy_d;
            pass_idx_q  <= pass_idx_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign rk_addr    = rk_addr_q;
    assign dp_en_col  = dp_en_q;
    assign dp_en_key  = dp_en_q;
    assign dp_col_din = dp_col_q;
    // Key RAM data arrives one cycle after the address, exactly when the strobe is up
    assign dp_key_din = dp_en_q ? rk_rdata : 8'h00;
    assign busy       = busy_q;
    assign pass_idx   = pass_idx_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with key RAM and round datapath models.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    localparam int NI  = 3;
    localparam int LIM = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NI-1:0]    in_valid_v, out_ready_v;
    logic [7:0]       in_byte_v   [NI];
    logic [NI-1:0]    in_ready_v, out_valid_v, dp_en_v, dp_enk_v, busy_v;
    logic [7:0]       out_byte_v  [NI];
    logic [7:0]       dp_col_v    [NI];
    logic [7:0]       dp_key_v    [NI];
    logic [7:0]       rk_addr_v   [NI];
    logic [3:0]       pass_idx_v  [NI];
    logic [7:0]       key_mem     [NI][256];

    int tests = 0;
    int fails = 0;

    // Instance 0: NPASS=1, instance 1: NPASS=11, instance 2: NPASS=2
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NPV = (g == 0) ? 1 : ((g == 1) ? 11 : 2);

        logic [7:0] rk_rdata;
        logic [7:0] dp_dout = 8'h00;
        logic       dp_enable_out = 1'b0;
        logic [7:0] rk_addr, dp_col, dp_key, out_byte;
        logic       dp_en_col, dp_en_key, in_ready, out_valid, busy;
        logic [3:0] pass_idx;

        aes_round_ctrl #(.NPASS(NPV), .RK_AW(8)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid_v[g]),
            .in_ready      (in_ready),
            .in_byte       (in_byte_v[g]),
            .out_valid     (out_valid),
            .out_ready     (out_ready_v[g]),
            .out_byte      (out_byte),
            .rk_addr       (rk_addr),
            .rk_rdata      (rk_rdata),
            .dp_col_din    (dp_col),
            .dp_key_din    (dp_key),
            .dp_en_col     (dp_en_col),
            .dp_en_key     (dp_en_key),
            .dp_dout       (dp_dout),
            .dp_enable_out (dp_enable_out),
            .busy          (busy),
            .pass_idx      (pass_idx)
        );

        assign in_ready_v[g]  = in_ready;
        assign out_valid_v[g] = out_valid;
        assign dp_en_v[g]     = dp_en_col;
        assign dp_enk_v[g]    = dp_en_key;
        assign busy_v[g]      = busy;
        assign out_byte_v[g]  = out_byte;
        assign dp_col_v[g]    = dp_col;
        assign dp_key_v[g]    = dp_key;
        assign rk_addr_v[g]   = rk_addr;
        assign pass_idx_v[g]  = pass_idx;

        // Synchronous-read key RAM
        always @(posedge clk) rk_rdata <= key_mem[g][rk_addr];

        // Standard datapath: XOR each byte pair, result stream starts two cycles
        // after the 16th input and holds byte 15 for one extra cycle
        logic [7:0] acc [16];
        int rx_cnt = 0;
        int tx_ph  = 0;
        int tx_i   = 0;
        always @(posedge clk) begin
            if (dp_en_col) begin
                acc[rx_cnt] <= dp_col ^ dp_key;
                if (rx_cnt == 15) begin
                    rx_cnt <= 0;
                    tx_ph  <= 1;
                end else begin
                    rx_cnt <= rx_cnt + 1;
                end
            end
            case (tx_ph)
                1: tx_ph <= 2;
                2: begin
                    dp_enable_out <= 1'b1;
                    dp_dout       <= acc[0];
                    tx_i          <= 1;
                    tx_ph         <= 3;
                end
                3: begin
                    if (tx_i < 16) begin
                        dp_dout <= acc[tx_i];
                        tx_i    <= tx_i + 1;
                    end else if (tx_i == 16) begin
                        tx_i <= 17;
                    end else begin
                        dp_enable_out <= 1'b0;
                        tx_ph         <= 0;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_ok(input string tag, input int n, input int lim);
        tests++;
        assert (n < lim) else begin
            fails++;
            $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, lim);
        end
    endtask

    task automatic load_block(input int g, input logic [7:0] d [16], input int first,
                              input bit keep_valid);
        int guard;
        for (int i = first; i < 16; i++) begin
            guard = 0;
            in_valid_v[g] = 1'b1;
            in_byte_v[g]  = d[i];
            while (!in_ready_v[g] && guard < LIM) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= LIM) bound_ok("load_wait", guard, LIM);
            @(posedge clk); #1;
        end
        if (!keep_valid) in_valid_v[g] = 1'b0;
    endtask

    // Count cycles from the final load handshake to out_valid; probe one FEED cycle
    task automatic wait_first_out(input int g, input int exp_lat, input int probe_n,
                                  input logic [3:0] p_pass, input logic [7:0] p_addr,
                                  input logic [7:0] p_col, input logic [7:0] p_key);
        int n;
        n = 0;
        while (!out_valid_v[g] && n < LIM) begin
            @(posedge clk); #1; n++;
            if (n == probe_n) begin
                check("probe_pass_idx", 32'(pass_idx_v[g]), 32'(p_pass));
                check("probe_rk_addr",  32'(rk_addr_v[g]),  32'(p_addr));
                check("probe_col",      32'(dp_col_v[g]),   32'(p_col));
                check("probe_key",      32'(dp_key_v[g]),   32'(p_key));
                check("probe_en_col",   32'(dp_en_v[g]),    32'd1);
                check("probe_en_key",   32'(dp_enk_v[g]),   32'd1);
                check("probe_busy",     32'(busy_v[g]),     32'd1);
            end
        end
        bound_ok("out_wait", n, LIM);
        check("first_out_latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic recv(input int g, input logic [7:0] exp [16], input int from, input int to);
        int guard;
        out_ready_v[g] = 1'b1;
        for (int j = from; j <= to; j++) begin
            guard = 0;
            while (!out_valid_v[g] && guard < LIM) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= LIM) bound_ok("recv_wait", guard, LIM);
            check($sformatf("out_byte[%0d]", j), 32'(out_byte_v[g]), 32'(exp[j]));
            @(posedge clk); #1;
        end
        out_ready_v[g] = 1'b0;
    endtask

    initial begin
        logic [7:0] d   [16];
        logic [7:0] e   [16];
        logic [7:0] d2  [16];
        int bad;
        int n;

        rst_n       = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        for (int g = 0; g < NI; g++) in_byte_v[g] = 8'h00;
        for (int a = 0; a < 256; a++) begin
            key_mem[0][a] = 8'h00;
            key_mem[1][a] = 8'hFF;
            key_mem[2][a] = 8'(a);
        end
        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready",  32'(in_ready_v[0]),  32'd0);
        check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("rst_busy",      32'(busy_v),         32'd0);
        check("rst_rk_addr",   32'(rk_addr_v[1]),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", 32'(in_ready_v[0]), 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready_after_edge", 32'(in_ready_v), 32'b111);

        // NPASS=1, zero keys: identity, 37-cycle latency
        for (int i = 0; i < 16; i++) begin d[i] = 8'(i); e[i] = 8'(i); end
        load_block(0, d, 0, 1'b0);
        check("busy_after_load", 32'(busy_v[0]), 32'd1);
        wait_first_out(0, 37, 5, 4'd0, 8'd5, 8'h04, 8'h00);
        recv(0, e, 0, 15);
        check("idle_busy", 32'(busy_v[0]), 32'd0);
        check("idle_out_valid", 32'(out_valid_v[0]), 32'd0);

        // NPASS=11, keys FF: odd number of XORs inverts every byte
        for (int i = 0; i < 16; i++) e[i] = 8'(i) ^ 8'hFF;
        load_block(1, d, 0, 1'b0);
        wait_first_out(1, 407, 116, 4'd3, 8'd53, 8'hFB, 8'hFF);
        recv(1, e, 0, 15);
        check("idle_busy_np11", 32'(busy_v[1]), 32'd0);

        // NPASS=2, key = address, zero input: every byte i ^ (16+i) = 0x10
        for (int i = 0; i < 16; i++) begin d[i] = 8'h00; e[i] = 8'h10; end
        load_block(2, d, 0, 1'b0);
        wait_first_out(2, 74, 1, 4'd0, 8'd1, 8'h00, 8'h00);
        recv(2, e, 0, 15);

        // Output stall: 20 cycles with out_ready low keeps the current byte
        for (int i = 0; i < 16; i++) begin d[i] = 8'hA0 + 8'(i); e[i] = d[i]; end
        load_block(0, d, 0, 1'b0);
        wait_first_out(0, 37, 1, 4'd0, 8'd1, 8'hA0, 8'h00);
        recv(0, e, 0, 4);
        for (int c = 0; c < 20; c++) begin
            check("stall_valid", 32'(out_valid_v[0]), 32'd1);
            check("stall_byte",  32'(out_byte_v[0]),  32'(e[5]));
            @(posedge clk); #1;
        end
        recv(0, e, 5, 15);
        check("stall_idle", 32'(busy_v[0]), 32'd0);

        // in_valid held high through a whole run
        for (int i = 0; i < 16; i++) begin d[i] = 8'h30 + 8'(i); e[i] = d[i]; end
        load_block(0, d, 0, 1'b1);
        in_byte_v[0] = 8'hEE;
        bad = 0;
        n = 0;
        while (!out_valid_v[0] && n < LIM) begin
            if (in_ready_v[0]) bad++;
            @(posedge clk); #1; n++;
        end
        bound_ok("hold_out_wait", n, LIM);
        check("hold_in_ready_busy", 32'(bad), 32'd0);
        check("hold_latency", 32'(n), 32'd37);
        check("hold_in_ready_out", 32'(in_ready_v[0]), 32'd0);
        recv(0, e, 0, 15);
        check("hold_back_idle_ready", 32'(in_ready_v[0]), 32'd1);
        check("hold_back_idle_busy",  32'(busy_v[0]),     32'd0);
        @(posedge clk); #1;
        check("hold_next_block_taken", 32'(busy_v[0]), 32'd1);

        // Finish that second block, then reset it in the middle of OUT
        d2[0] = 8'hEE;
        for (int i = 1; i < 16; i++) d2[i] = 8'h50 + 8'(i);
        load_block(0, d2, 1, 1'b0);
        wait_first_out(0, 37, 1, 4'd0, 8'd1, 8'hEE, 8'h00);
        recv(0, d2, 0, 2);
        check("pre_rst_valid", 32'(out_valid_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready_v[0]),  32'd0);
        check("mid_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("mid_rst_out_byte",  32'(out_byte_v[0]),  32'd0);
        check("mid_rst_dp_en",     32'(dp_en_v[0]),     32'd0);
        check("mid_rst_dp_enk",    32'(dp_enk_v[0]),    32'd0);
        check("mid_rst_col",       32'(dp_col_v[0]),    32'd0);
        check("mid_rst_key",       32'(dp_key_v[0]),    32'd0);
        check("mid_rst_rk_addr",   32'(rk_addr_v[0]),   32'd0);
        check("mid_rst_busy",      32'(busy_v[0]),      32'd0);
        check("mid_rst_pass_idx",  32'(pass_idx_v[0]),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_rst_ready_before", 32'(in_ready_v[0]), 32'd0);
        @(posedge clk); #1;
        check("post_rst_ready_after", 32'(in_ready_v[0]), 32'd1);
        check("post_rst_busy",        32'(busy_v[0]),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the byte-serial AddRoundKey round datapath. Accepts a 16-byte block as a byte stream and runs NPASS passes through the datapath. Each pass feeds 16 state bytes plus 16 round-key bytes fetched from the round-key store, then captures the 16 result bytes back into the state buffer. After the final pass it streams the 16 result bytes out. It sits between the block input stream, the round-key RAM and one round datapath instance.

## Interface
- NPASS, 11: passes per block; round keys 0..NPASS-1.
- RK_AW, 8: round-key address width; must satisfy 2^RK_AW ≥ NPASS*16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. Single clock domain.
- in_valid / in_ready / in_byte  in/out/in  1/1/8  block load stream; transfer on valid&&ready; byte 0 first.
- out_valid / out_ready / out_byte  out/in/out  1/1/8  result stream; transfer on valid&&ready; byte 0 first.
- rk_addr  out  RK_AW  round-key byte address = pass*16 + byte index.
- rk_rdata  in  8  key RAM data; valid one cycle after rk_addr (synchronous read).
- dp_col_din, dp_key_din  out  8  datapath byte inputs.
- dp_en_col, dp_en_key  out  1  datapath load strobes; always driven identically.
- dp_dout  in  8  datapath result byte.
- dp_enable_out  in  1  datapath result valid.
- busy  out  1  high in every state except IDLE.
- pass_idx  out  4  current pass number (0..NPASS-1); 0 outside FEED/CAPTURE/GAP.

## Operation
- States: IDLE, LOAD, FEED, CAPTURE, GAP, OUT.
- IDLE: in_ready=1. The first in handshake writes buf[0] and moves to LOAD.
- LOAD: in_ready=1. Handshakes fill buf[1..15]. The 16th byte moves to FEED with pass_idx=0.
- FEED runs 17 cycles, k=0..16.
  - k=0: rk_addr=pass*16. Strobes low.
  - k=1..16: dp_en_*=1, dp_col_din=buf[k-1], dp_key_din=rk_rdata, rk_addr=pass*16+k (k≤15).
  - After k=16: go to CAPTURE.
- CAPTURE: each cycle with dp_enable_out=1 writes dp_dout into buf[cnt] and increments cnt. After cnt reaches 16: go to GAP.
  - The datapath holds dp_enable_out one extra cycle, repeating byte 15. That cycle must not be written.
- GAP: wait until dp_enable_out=0.
  - If pass<NPASS-1: pass++ and go to FEED.
  - Otherwise: go to OUT.
- OUT: out_valid=1, out_byte=buf[j]. j advances on handshake. After the 16th handshake go to IDLE.
- Strobes are never asserted outside FEED k=1..16.
- Reset values: in_ready=0, out_valid=0, out_byte=0, dp_en_*=0, dp_*_din=0, rk_addr=0, busy=0, pass_idx=0, all counters 0, state IDLE.
  - in_ready rises the first cycle after rst_n deasserts.
  - Buffer contents are not reset.
- Reset mid-operation:
  - Controller returns to IDLE immediately.
  - The round datapath has no reset. Reset during FEED or CAPTURE leaves it mid-pass. Recovery requires a datapath power-up, and system use forbids it.
  - Verification checks controller outputs only for this case.
- in_valid while busy is ignored (in_ready=0). out_ready low stalls OUT indefinitely, with out_byte stable.

## Timing
- Pass period with the standard datapath is 37 cycles:
  - FEED: cycles 0–16.
  - Datapath idle: cycle 17.
  - Datapath latches b0: end of 18. dp_enable_out high cycles 19–35; captures at 19–34.
  - GAP sees enable low: cycle 36.
- First out_valid: NPASS*37 cycles after the cycle of the final in handshake (407 for NPASS=11).
- Minimum block period: 16 load + NPASS*37 + 16 out cycles. There is no overlap between blocks.
- The controller relies on dp_enable_out edges, not fixed counts. Its correctness is independent of datapath latency.

## Structure
- Shared package aes_pkg:
  - AES_BLOCK_BYTES=16.
  - The state enum.
  - Default NPASS.
  - Key address helper (pass*16+byte).
- One sub-module, aes_state_buf: 16×8 register file with one write port and one async read port. Used for both the load and capture writes.

## Test plan
- Load 00..0F, key RAM all 00, NPASS=1 -> out 00..0F; out_valid rises 37 cycles after the last in handshake.
- Load 00..0F, key RAM byte i = 0xFF, NPASS=11 -> 11 XORs (odd count); out = FF..F0; first out at +407.
- Key RAM pass p byte i = p*16+i, NPASS=2, input all 00 -> out[i] = i ^ (16+i) = 0x10 for every byte. This confirms the repeated byte 15 is not captured.
- Hold out_ready=0 for 20 cycles mid-OUT -> out_byte and out_valid stable; no byte lost or duplicated.
- in_valid held high throughout a run -> in_ready=0 from FEED through OUT; the next block loads only after return to IDLE.
- Assert rst_n=0 during OUT -> all outputs take reset values asynchronously; in_ready=1 the first cycle after release.
